line_follow_ctrl: RTL and testbench

Parametrised line-following controller for the bot's drive path. It sits between the LFA sensor front end and the motor PWM generator. It classifies three ADC sensor samples against configurable thresholds and debounces node (junction) crossings. At each node it executes a per-node turn command from the path planner, and it drives direction bits plus duty codes to both motors.

---
 rtl/lf_pkg.sv | 56 +++++
 rtl/lf_classify.sv | 39 +++
 rtl/line_follow_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_line_follow_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lf_pkg.sv
// Shared types for the line-following controller: FSM states, sensor classes,
// turn commands and motor codes with their direction-bit encodings.
package lf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FOLLOW,
    ST_NODE,
    ST_TURN_A,
    ST_TURN_B,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALL,
    CLS_RIGHT,
    CLS_LEFT,
    CLS_CENTER,
    CLS_NONE,
    CLS_HOLD
  } sclass_t;

  typedef enum logic [1:0] {
    TURN_STRAIGHT = 2'b00,
    TURN_LEFT     = 2'b01,
    TURN_RIGHT    = 2'b10,
    TURN_STOP     = 2'b11
  } turn_t;

  typedef enum logic [2:0] {
    MC_STOP,
    MC_FWD,
    MC_CORR_R,
    MC_CORR_L,
    MC_PIV_R,
    MC_PIV_L
  } mcode_t;

  // Direction pair {a, b} for one motor.
  localparam logic [1:0] DIR_OFF = 2'b00;
  localparam logic [1:0] DIR_FWD = 2'b10;
  localparam logic [1:0] DIR_REV = 2'b01;

  // Returns {m1_a, m1_b, m2_a, m2_b} for a motor code.
  function automatic logic [3:0] mcodeDirs(input mcode_t code);
    logic [3:0] dirs;
    case (code)
      MC_FWD:              dirs = {DIR_FWD, DIR_FWD};
      MC_CORR_R, MC_PIV_R: dirs = {DIR_FWD, DIR_REV};
      MC_CORR_L, MC_PIV_L: dirs = {DIR_REV, DIR_FWD};
      default:             dirs = {DIR_OFF, DIR_OFF};
    endcase
    return dirs;
  endfunction

endpackage

// File: rtl/lf_classify.sv
// Combinational sensor classifier: maps left/middle/right samples to a class
// in priority order, and exposes the middle-sensor high/low flags.
module lf_classify
  import lf_pkg::*;
#(
  parameter int ADC_W = 12
) (
  input  logic [ADC_W-1:0] i_left,
  input  logic [ADC_W-1:0] i_middle,
  input  logic [ADC_W-1:0] i_right,
  input  logic [ADC_W-1:0] i_hiTh,
  input  logic [ADC_W-1:0] i_loTh,
  output sclass_t          o_class,
  output logic             o_midHigh,
  output logic             o_midLow
);

  logic w_hl, w_hm, w_hr, w_ll, w_lm, w_lr;

  assign w_hl = (i_left   > i_hiTh);
  assign w_hm = (i_middle > i_hiTh);
  assign w_hr = (i_right  > i_hiTh);
  assign w_ll = (i_left   < i_loTh);
  assign w_lm = (i_middle < i_loTh);
  assign w_lr = (i_right  < i_loTh);

  assign o_midHigh = w_hm;
  assign o_midLow  = w_lm;

  always_comb begin
    o_class = CLS_HOLD;
    if (w_hl && w_hm && w_hr)      o_class = CLS_ALL;
    else if (w_hr && w_ll)         o_class = CLS_RIGHT;
    else if (w_hl && w_lr)         o_class = CLS_LEFT;
    else if (w_ll && w_hm && w_lr) o_class = CLS_CENTER;
    else if (w_ll && w_lm && w_lr) o_class = CLS_NONE;
  end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following controller: classifies LFA samples, debounces nodes, executes
// per-node turns and drives registered motor direction bits and duty codes.
// Optional lost-line recovery is built when LF_LOST_LINE_EN is defined.
module line_follow_ctrl
  import lf_pkg::*;
#(
  parameter int ADC_W  = 12,
  parameter int DUTY_W = 4,
  parameter int NODE_W = 8,
  parameter int HI_TH  = 1000,
  parameter int LO_TH  = 200,
  parameter int DEB_N  = 4,
  parameter int D_FWD  = 7,
  parameter int D_FAST = 8,
  parameter int D_SLOW = 3,
  parameter int D_PIV  = 5
`ifdef LF_LOST_LINE_EN
  , parameter int LOST_N = 64
`endif
) (
  input  logic              clk_3125KHz,
  input  logic              rst,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [ADC_W-1:0]  left,
  input  logic [ADC_W-1:0]  middle,
  input  logic [ADC_W-1:0]  right,
  input  logic [1:0]        turn_cmd,
  output logic              m1_a,
  output logic              m1_b,
  output logic              m2_a,
  output logic              m2_b,
  output logic [DUTY_W-1:0] dc1,
  output logic [DUTY_W-1:0] dc2,
  output logic              node_flag,
  output logic [NODE_W-1:0] node_count,
  output logic              running,
  output logic              done
);

  localparam int DEB_W = $clog2(DEB_N + 1);

  function automatic logic [2*DUTY_W-1:0] dutyOf(input mcode_t code);
    logic [2*DUTY_W-1:0] duty;
    case (code)
      MC_FWD:              duty = {DUTY_W'(D_FWD),  DUTY_W'(D_FWD)};
      MC_CORR_R:           duty = {DUTY_W'(D_FAST), DUTY_W'(D_SLOW)};
      MC_CORR_L:           duty = {DUTY_W'(D_SLOW), DUTY_W'(D_FAST)};
      MC_PIV_R, MC_PIV_L:  duty = {DUTY_W'(D_PIV),  DUTY_W'(D_PIV)};
      default:             duty = '0;
    endcase
    return duty;
  endfunction

  sclass_t           w_class;
  logic              w_midHigh, w_midLow;
  state_t            r_state, w_stateNext;
  mcode_t            r_code, w_codeNext;
  logic [DEB_W-1:0]  r_deb, w_debNext;
  turn_t             r_turn, w_turnNext;
  logic              w_nodeFlagNext;
  logic [NODE_W-1:0] w_nodeCountNext;
  logic [3:0]        w_dirsNext;
  logic [2*DUTY_W-1:0] w_dutyNext;

`ifdef LF_LOST_LINE_EN
  localparam int LOST_W = $clog2(LOST_N + 1);
  logic [LOST_W-1:0] r_lost, w_lostNext;
  logic              r_lastRight, w_lastRightNext;
  logic              r_recover, w_recoverNext;
`endif

  lf_classify #(.ADC_W(ADC_W)) u_classify (
    .i_left    (left),
    .i_middle  (middle),
    .i_right   (right),
    .i_hiTh    (ADC_W'(HI_TH)),
    .i_loTh    (ADC_W'(LO_TH)),
    .o_class   (w_class),
    .o_midHigh (w_midHigh),
    .o_midLow  (w_midLow)
  );

  always_comb begin
    w_stateNext     = r_state;
    w_codeNext      = r_code;
    w_debNext       = r_deb;
    w_turnNext      = r_turn;
    w_nodeFlagNext  = node_flag;
    w_nodeCountNext = node_count;
`ifdef LF_LOST_LINE_EN
    w_lostNext      = r_lost;
    w_lastRightNext = r_lastRight;
    w_recoverNext   = r_recover;
`endif
    case (r_state)
      ST_IDLE: begin
        w_codeNext = MC_STOP;
        if (start) w_stateNext = ST_FOLLOW;
      end
      ST_FOLLOW: begin
        if (sample_valid) begin
          case (w_class)
            CLS_RIGHT:  w_codeNext = MC_CORR_R;
            CLS_LEFT:   w_codeNext = MC_CORR_L;
            CLS_CENTER: w_codeNext = MC_FWD;
            default:    w_codeNext = r_code;
          endcase
`ifdef LF_LOST_LINE_EN
          if (w_class == CLS_RIGHT)     w_lastRightNext = 1'b1;
          else if (w_class == CLS_LEFT) w_lastRightNext = 1'b0;
          if (w_class == CLS_NONE && !r_recover) begin
            if (r_lost == LOST_W'(LOST_N - 1)) begin
              w_lostNext    = '0;
              w_recoverNext = 1'b1;
              w_codeNext    = r_lastRight ? MC_PIV_R : MC_PIV_L;
            end else begin
              w_lostNext = r_lost + 1'b1;
            end
          end else begin
            w_lostNext = '0;
          end
          // Recovery keeps pivoting regardless of class until the middle sees the line.
          if (r_recover) begin
            if (w_midHigh) begin
              w_recoverNext = 1'b0;
              w_codeNext    = MC_FWD;
            end else begin
              w_codeNext = r_code;
            end
          end
`endif
          if (w_class == CLS_ALL) begin
            if (r_deb == DEB_W'(DEB_N - 1)) begin
              w_debNext      = '0;
              w_stateNext    = ST_NODE;
              w_nodeFlagNext = 1'b1;
              w_turnNext     = turn_t'(turn_cmd);
              w_codeNext     = (turn_t'(turn_cmd) == TURN_STOP) ? MC_STOP : MC_FWD;
`ifdef LF_LOST_LINE_EN
              w_recoverNext  = 1'b0;
              w_lostNext     = '0;
`endif
            end else begin
              w_debNext = r_deb + 1'b1;
            end
          end else begin
            w_debNext = '0;
          end
        end
      end
      ST_NODE: begin
        if (r_turn == TURN_STOP) begin
          w_stateNext = ST_DONE;
        end else if (sample_valid && w_class != CLS_ALL) begin
          w_nodeCountNext = node_count + 1'b1;
          w_nodeFlagNext  = 1'b0;
          case (r_turn)
            TURN_LEFT: begin
              w_stateNext = ST_TURN_A;
              w_codeNext  = MC_PIV_L;
            end
            TURN_RIGHT: begin
              w_stateNext = ST_TURN_A;
              w_codeNext  = MC_PIV_R;
            end
            default: w_stateNext = ST_FOLLOW;
          endcase
        end
      end
      ST_TURN_A: begin
        if (sample_valid && w_midLow) w_stateNext = ST_TURN_B;
      end
      ST_TURN_B: begin
        if (sample_valid && w_midHigh) begin
          w_stateNext = ST_FOLLOW;
          w_codeNext  = MC_FWD;
        end
      end
      ST_DONE: w_codeNext = MC_STOP;
      default: begin
        w_stateNext = ST_IDLE;
        w_codeNext  = MC_STOP;
      end
    endcase
  end

  assign w_dirsNext = mcodeDirs(w_codeNext);
  assign w_dutyNext = dutyOf(w_codeNext);

  // Outputs are registered from the next-state values so they change on the consuming edge.
  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_code     <= MC_STOP;
      r_deb      <= '0;
      r_turn     <= TURN_STRAIGHT;
      node_flag  <= 1'b0;
      node_count <= '0;
      {m1_a, m1_b, m2_a, m2_b} <= 4'b0000;
      dc1        <= '0;
      dc2        <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_code     <= w_codeNext;
      r_deb      <= w_debNext;
      r_turn     <= w_turnNext;
      node_flag  <= w_nodeFlagNext;
      node_count <= w_nodeCountNext;
      {m1_a, m1_b, m2_a, m2_b} <= w_dirsNext;
      {dc1, dc2} <= w_dutyNext;
      running    <= (w_stateNext != ST_IDLE) && (w_stateNext != ST_DONE);
      done       <= (w_stateNext == ST_DONE);
    end
  end

`ifdef LF_LOST_LINE_EN
  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      r_lost      <= '0;
      r_lastRight <= 1'b1;
      r_recover   <= 1'b0;
    end else begin
      r_lost      <= w_lostNext;
      r_lastRight <= w_lastRightNext;
      r_recover   <= w_recoverNext;
    end
  end
`endif

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed self-checking bench for line_follow_ctrl; the lost-line section is
// exercised when LF_LOST_LINE_EN is defined.
module tb_line_follow_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sampleValid;
  logic [11:0] leftS, middleS, rightS;
  logic [1:0]  turnCmd;
  logic        m1A, m1B, m2A, m2B;
  logic [3:0]  dc1, dc2;
  logic        nodeFlag;
  logic [7:0]  nodeCount;
  logic        running, done;

  int checks = 0;
  int failures = 0;

  logic [31:0] motorObs;
  assign motorObs = {20'd0, m1A, m1B, m2A, m2B, dc1, dc2};

  line_follow_ctrl dut (
    .clk_3125KHz  (clk),
    .rst          (rst),
    .start        (start),
    .sample_valid (sampleValid),
    .left         (leftS),
    .middle       (middleS),
    .right        (rightS),
    .turn_cmd     (turnCmd),
    .m1_a         (m1A),
    .m1_b         (m1B),
    .m2_a         (m2A),
    .m2_b         (m2B),
    .dc1          (dc1),
    .dc2          (dc2),
    .node_flag    (nodeFlag),
    .node_count   (nodeCount),
    .running      (running),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] motorOf(input logic [1:0] m1, input logic [1:0] m2,
                                          input logic [3:0] d1, input logic [3:0] d2);
    return {20'd0, m1, m2, d1, d2};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] l, input logic [11:0] m, input logic [11:0] r);
    @(negedge clk);
    leftS = l; middleS = m; rightS = r;
    sampleValid = 1'b1;
    @(posedge clk);
    #1;
    sampleValid = 1'b0;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    sampleValid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] mStop, mFwd, mCorrR, mCorrL, mPivL, mPivR;
    mStop  = motorOf(2'b00, 2'b00, 4'd0, 4'd0);
    mFwd   = motorOf(2'b10, 2'b10, 4'd7, 4'd7);
    mCorrR = motorOf(2'b10, 2'b01, 4'd8, 4'd3);
    mCorrL = motorOf(2'b01, 2'b10, 4'd3, 4'd8);
    mPivL  = motorOf(2'b01, 2'b10, 4'd5, 4'd5);
    mPivR  = motorOf(2'b10, 2'b01, 4'd5, 4'd5);

    rst = 1'b1; start = 1'b0; sampleValid = 1'b0; turnCmd = 2'b00;
    leftS = '0; middleS = '0; rightS = '0;
    #12;
    checkOutput("reset_motor", motorObs, mStop);
    checkOutput("reset_flags", {28'd0, nodeFlag, running, done, 1'b0}, 32'd0);
    checkOutput("reset_count", {24'd0, nodeCount}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    pulseStart();
    checkOutput("start_running", {31'd0, running}, 32'd1);
    checkOutput("start_motor_stop", motorObs, mStop);

    applyStimulus(12'd100, 12'd2000, 12'd100);
    checkOutput("center_fwd", motorObs, mFwd);
    applyStimulus(12'd100, 12'd500, 12'd2000);
    checkOutput("right_corr", motorObs, mCorrR);
    applyStimulus(12'd2000, 12'd500, 12'd100);
    checkOutput("left_corr", motorObs, mCorrL);
    applyStimulus(12'd500, 12'd500, 12'd500);
    checkOutput("hold_keeps", motorObs, mCorrL);
    applyStimulus(12'd100, 12'd100, 12'd100);
    checkOutput("none_keeps", motorObs, mCorrL);
    applyStimulus(12'd100, 12'd2000, 12'd100);
    checkOutput("center_again", motorObs, mFwd);

    // Three ALL samples fall one short of a node.
    repeat (3) applyStimulus(12'd2000, 12'd2000, 12'd2000);
    checkOutput("deb3_no_flag", {31'd0, nodeFlag}, 32'd0);
    checkOutput("deb3_motor", motorObs, mFwd);
    applyStimulus(12'd100, 12'd2000, 12'd100);
    checkOutput("deb_broken", {31'd0, nodeFlag}, 32'd0);

    turnCmd = 2'b00;
    repeat (3) applyStimulus(12'd2000, 12'd2000, 12'd2000);
    checkOutput("deb_pre_flag", {31'd0, nodeFlag}, 32'd0);
    applyStimulus(12'd2000, 12'd2000, 12'd2000);
    checkOutput("node_flag_set", {31'd0, nodeFlag}, 32'd1);
    turnCmd = 2'b01;
    applyStimulus(12'd100, 12'd2000, 12'd100);
    checkOutput("node1_count", {24'd0, nodeCount}, 32'd1);
    checkOutput("node1_flag_clr", {31'd0, nodeFlag}, 32'd0);
    checkOutput("node1_straight", motorObs, mFwd);

    repeat (4) applyStimulus(12'd2000, 12'd2000, 12'd2000);
    checkOutput("node2_flag", {31'd0, nodeFlag}, 32'd1);
    applyStimulus(12'd100, 12'd2000, 12'd100);
    checkOutput("node2_count", {24'd0, nodeCount}, 32'd2);
    checkOutput("node2_pivl", motorObs, mPivL);
    applyStimulus(12'd100, 12'd2000, 12'd100);
    checkOutput("turna_hold_high", motorObs, mPivL);
    applyStimulus(12'd100, 12'd100, 12'd100);
    checkOutput("turna_low", motorObs, mPivL);
    applyStimulus(12'd100, 12'd500, 12'd100);
    checkOutput("turnb_hold", motorObs, mPivL);
    applyStimulus(12'd100, 12'd2000, 12'd100);
    checkOutput("turnb_exit_fwd", motorObs, mFwd);
    checkOutput("turnb_running", {31'd0, running}, 32'd1);

    // Stop node, with invalid all-high cycles inside the debounce run.
    turnCmd = 2'b11;
    repeat (3) applyStimulus(12'd2000, 12'd2000, 12'd2000);
    leftS = 12'd2000; middleS = 12'd2000; rightS = 12'd2000;
    idleCycle();
    idleCycle();
    checkOutput("invalid_no_count", {31'd0, nodeFlag}, 32'd0);
    applyStimulus(12'd2000, 12'd2000, 12'd2000);
    checkOutput("stop_node_flag", {31'd0, nodeFlag}, 32'd1);
    checkOutput("stop_node_motor", motorObs, mStop);
    idleCycle();
    checkOutput("done_set", {30'd0, done, running}, 32'd2);
    checkOutput("done_count", {24'd0, nodeCount}, 32'd2);
    pulseStart();
    checkOutput("done_ignores_start", {30'd0, done, running}, 32'd2);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checkOutput("rst_from_done", {24'd0, nodeCount}, 32'd0);
    checkOutput("rst_done_clr", {31'd0, done}, 32'd0);
    pulseStart();
    turnCmd = 2'b00;
    applyStimulus(12'd100, 12'd2000, 12'd100);
    checkOutput("restart_fwd", motorObs, mFwd);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_motor", motorObs, mStop);
    checkOutput("async_rst_running", {31'd0, running}, 32'd0);
    @(negedge clk); rst = 1'b0;
    applyStimulus(12'd100, 12'd2000, 12'd100);
    checkOutput("idle_after_rst", motorObs, mStop);

    pulseStart();
    applyStimulus(12'd100, 12'd500, 12'd2000);
    checkOutput("lost_pre_corr", motorObs, mCorrR);
`ifdef LF_LOST_LINE_EN
    repeat (63) applyStimulus(12'd100, 12'd100, 12'd100);
    checkOutput("lost_63_hold", motorObs, mCorrR);
    applyStimulus(12'd100, 12'd100, 12'd100);
    checkOutput("lost_64_pivr", motorObs, mPivR);
    applyStimulus(12'd100, 12'd500, 12'd100);
    checkOutput("lost_recover_hold", motorObs, mPivR);
    applyStimulus(12'd100, 12'd2000, 12'd100);
    checkOutput("lost_found_fwd", motorObs, mFwd);
    checkOutput("lost_count", {24'd0, nodeCount}, 32'd0);
`else
    repeat (70) applyStimulus(12'd100, 12'd100, 12'd100);
    checkOutput("none_holds_long", motorObs, mCorrR);
    checkOutput("none_running", {31'd0, running}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
